// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_if
// Brief   : Request/writeback bundle between the pipeline and muldiv_unit.
// Revision: 1.0 - initial release
// ============================================================================
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_i;
    logic            flush;
    logic            busy;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    modport master (
        output start, funct3, rs1_data, rs2_data, rd_i, flush,
        input  busy, wb_we, wb_rd, wb_data
    );

    modport slave (
        input  start, funct3, rs1_data, rs2_data, rd_i, flush,
        output busy, wb_we, wb_rd, wb_data
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_unit
// Brief   : Iterative RV32M multiply/divide, one bit per cycle, registered writeback.
// Revision: 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  wire logic clk,
    input  wire logic reset,
    muldiv_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   opd_q, opd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              busy_q, busy_d;
    logic              wb_we_q, wb_we_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;

    logic              sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag, special_res;

    always_comb begin
        sgn_a    = (bus.funct3 == F_MULH) || (bus.funct3 == F_MULHSU) ||
                   (bus.funct3 == F_DIV)  || (bus.funct3 == F_REM);
        sgn_b    = (bus.funct3 == F_MULH) || (bus.funct3 == F_DIV) || (bus.funct3 == F_REM);
        a_neg    = sgn_a & bus.rs1_data[XLEN-1];
        b_neg    = sgn_b & bus.rs2_data[XLEN-1];
        a_mag    = a_neg ? -bus.rs1_data : bus.rs1_data;
        b_mag    = b_neg ? -bus.rs2_data : bus.rs2_data;
        div_zero = bus.funct3[2] && (bus.rs2_data == '0);
        div_ovf  = bus.funct3[2] && !bus.funct3[0] &&
                   (bus.rs1_data == INT_MIN) && (bus.rs2_data == '1);
        if (div_zero)
            special_res = bus.funct3[1] ? bus.rs1_data : '1;
        else
            special_res = bus.funct3[1] ? '0 : INT_MIN;
    end

    // Accumulator layout: high word = partial product / remainder,
    // low word = remaining multiplier bits / dividend-then-quotient bits.
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, step_next, prod_s;
    logic [XLEN-1:0]   div_raw, div_s, result;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_sh    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_sh - {1'b0, opd_q};
        if (div_diff[XLEN])
            div_next = {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        else
            div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        step_next = op_q[2] ? div_next : mul_next;
        prod_s    = neg_q ? -mul_next : mul_next;
        div_raw   = op_q[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
        div_s     = neg_q ? -div_raw : div_raw;
        if (op_q[2])
            result = div_s;
        else if (op_q[1:0] == 2'b00)
            result = prod_s[XLEN-1:0];
        else
            result = prod_s[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_d     = neg_q;
        opd_d     = opd_q;
        acc_d     = acc_q;
        wb_we_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    op_d    = bus.funct3;
                    neg_d   = (bus.funct3 == F_REM) ? a_neg : (a_neg ^ b_neg);
                    cnt_d   = '0;
                    wb_rd_d = bus.rd_i;
                    if (bus.funct3[2]) begin
                        acc_d = {{XLEN{1'b0}}, a_mag};
                        opd_d = b_mag;
                    end else begin
                        acc_d = {{XLEN{1'b0}}, b_mag};
                        opd_d = a_mag;
                    end
                    if (div_zero || div_ovf) begin
                        state_d   = S_DONE;
                        wb_data_d = special_res;
                        wb_we_d   = 1'b1;
                    end else begin
                        state_d   = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = step_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d   = S_DONE;
                        wb_data_d = result;
                        wb_we_d   = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            opd_q     <= '0;
            acc_q     <= '0;
            busy_q    <= 1'b0;
            wb_we_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            opd_q     <= opd_d;
            acc_q     <= acc_d;
            busy_q    <= busy_d;
            wb_we_q   <= wb_we_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.wb_we   = wb_we_q;
    assign bus.wb_rd   = wb_rd_q;
    assign bus.wb_data = wb_data_q;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_muldiv_unit
// Brief   : Scoreboard bench for muldiv_unit against an arithmetic RV32M model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    localparam int XLEN = 32;
    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    logic clk = 1'b0;
    logic reset;

    muldiv_if #(.XLEN(XLEN)) bus ();
    muldiv_unit #(.XLEN(XLEN), .CNT_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_data = 32'h0;

    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          p;
        longint unsigned pu;
        case (f)
            MUL:    begin pu = 64'(a) * 64'(b); return pu[31:0]; end
            MULH:   begin p = longint'($signed(a)) * longint'($signed(b)); return p[63:32]; end
            MULHSU: begin p = longint'($signed(a)) * longint'({32'h0, b}); return p[63:32]; end
            MULHU:  begin pu = 64'(a) * 64'(b); return pu[63:32]; end
            DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'($signed(a) / $signed(b));
            end
            DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'($signed(a) % $signed(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected result.
    always @(negedge clk) begin
        if (reset !== 1'b1 && bus.wb_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_wb: wb_rd=%0d wb_data=%h, none expected",
                         bus.wb_rd, bus.wb_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.wb_data !== mon_e.data || bus.wb_rd !== mon_e.rd) begin
                    errors++;
                    $display("FAIL wb_result: got rd=%0d data=%h expected rd=%0d data=%h",
                             bus.wb_rd, bus.wb_data, mon_e.rd, mon_e.data);
                end
            end
        end
    end

    task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        bus.start    = 1'b1;
        bus.funct3   = f;
        bus.rs1_data = a;
        bus.rs2_data = b;
        bus.rd_i     = rd;
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input bit poke);
        int   n;
        int   busy_bad;
        bit   special;
        exp_t e;
        special = f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        e.rd    = rd;
        e.data  = ref_result(f, a, b);
        exp_q.push_back(e);
        last_data = e.data;
        busy_bad  = 0;
        drive(f, a, b, rd);
        @(posedge clk);
        n = 1;
        @(negedge clk);
        bus.start = 1'b0;
        while (bus.wb_we !== 1'b1 && n < 100) begin
            if (bus.busy !== 1'b1) busy_bad++;
            if (poke && n == 5) drive(f ^ 3'b001, ~a, b + 32'd1, rd + 5'd1);
            else bus.start = 1'b0;
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("latency", 32'(n), special ? 32'd1 : 32'd33);
        check("busy_during_op", 32'(busy_bad), 32'd0);
        check("busy_at_wb", 32'(bus.busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("busy_after_wb", 32'(bus.busy), 32'd0);
        check("wb_we_single", 32'(bus.wb_we), 32'd0);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0;
        bus.rs1_data = '0; bus.rs2_data = '0; bus.rd_i = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_wb_we", 32'(bus.wb_we), 32'd0);
        check("reset_wb_rd", 32'(bus.wb_rd), 32'd0);
        check("reset_wb_data", bus.wb_data, 32'd0);

        run_op(MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'd1, 1'b0);
        run_op(MULH,   32'h8000_0000, 32'h8000_0000, 5'd2, 1'b0);
        run_op(MULHSU, 32'h8000_0000, 32'h8000_0000, 5'd3, 1'b0);
        run_op(MULHU,  32'h8000_0000, 32'h8000_0000, 5'd4, 1'b0);
        run_op(DIV,    32'hFFFF_FFF9, 32'h0000_0002, 5'd5, 1'b0);
        run_op(REM,    32'hFFFF_FFF9, 32'h0000_0002, 5'd6, 1'b0);
        run_op(DIVU,   32'hFFFF_FFFF, 32'h0000_0010, 5'd7, 1'b0);
        run_op(REMU,   32'hFFFF_FFFF, 32'h0000_0010, 5'd8, 1'b0);
        run_op(DIV,    32'h0000_1234, 32'h0000_0000, 5'd9, 1'b0);
        run_op(REMU,   32'h0000_1234, 32'h0000_0000, 5'd10, 1'b0);
        run_op(DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0);
        run_op(REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0);
        run_op(MUL,    32'h0001_2345, 32'h0000_0100, 5'd0, 1'b1);

        // Flush at CALC cycle 10: no strobe, result register untouched.
        drive(MUL, 32'h0000_0005, 32'h0000_0006, 5'd13);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", 32'(bus.busy), 32'd0);
        check("flush_wb_we", 32'(bus.wb_we), 32'd0);
        check("flush_wb_data", bus.wb_data, last_data);
        repeat (40) @(negedge clk);

        // Flush together with start in IDLE: nothing accepted.
        drive(DIVU, 32'h0000_0064, 32'h0000_0007, 5'd14);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_start_busy", 32'(bus.busy), 32'd0);
        repeat (40) @(negedge clk);
        check("flush_start_wb_data", bus.wb_data, last_data);

        // Reset during CALC.
        drive(MULH, 32'h1234_5678, 32'h9ABC_DEF0, 5'd15);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_busy", 32'(bus.busy), 32'd0);
        check("midreset_wb_we", 32'(bus.wb_we), 32'd0);
        check("midreset_wb_rd", 32'(bus.wb_rd), 32'd0);
        check("midreset_wb_data", bus.wb_data, 32'd0);
        run_op(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd23, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), rand_opnd(), rand_opnd(),
                   5'($urandom_range(0, 31)), 1'b0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
